// File: rtl/ws2812b_serializer.sv
// WS2812B single-wire NRZ serializer: shifts one 24-bit GRB word out MSB first,
// optionally followed by a low latch period, behind a valid/ready handshake.
module ws2812b_serializer #(
    parameter int unsigned T0H_CYCLES   = 26,
    parameter int unsigned T1H_CYCLES   = 51,
    parameter int unsigned BIT_CYCLES   = 80,
    parameter int unsigned LATCH_CYCLES = 5120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] data_in,
    input  logic        valid,
    input  logic        latch,
    output logic        ready,
    output logic        led
);

    localparam int unsigned CNT_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
          T1H_CYCLES < BIT_CYCLES && LATCH_CYCLES >= 1)) begin : g_param_check
        $error("ws2812b_serializer: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIT,
        S_LATCH
    } state_e;

    state_e        state_q, state_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          latch_q, latch_d;
    logic          led_q, led_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cyc_q     <= '0;
            latch_q   <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_q     <= cyc_d;
            latch_q   <= latch_d;
            led_q     <= led_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cyc_d     = cyc_q;
        latch_d   = latch_q;

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    shift_d   = data_in;
                    latch_d   = latch;
                    bit_cnt_d = 5'd23;
                    cyc_d     = '0;
                    state_d   = S_BIT;
                end
            end
            S_BIT: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    shift_d = {shift_q[22:0], 1'b0};
                    if (bit_cnt_q == 5'd0) begin
                        state_d = latch_q ? S_LATCH : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_LATCH: begin
                if (cyc_q == LATCH_LAST) begin
                    cyc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // led is registered from the next-cycle position so it matches the
        // bit/count the FSM occupies during that cycle, with no glitches.
        led_d = (state_d == S_BIT) && (cyc_d < (shift_d[23] ? T1H : T0H));
    end

    assign ready = (state_q == S_IDLE);
    assign led   = led_q;

endmodule

// File: tb/tb_ws2812b_serializer.sv
// Self-checking bench for ws2812b_serializer: a pulse monitor decodes led into
// (rise cycle, high width) records checked against widths queued at stimulus time.
module tb_ws2812b_serializer;

    localparam int T0H    = 26;
    localparam int T1H    = 51;
    localparam int BITC   = 80;
    localparam int LATCHC = 5120;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] data_in;
    logic        valid;
    logic        latch;
    logic        ready;
    logic        led;

    int n_cmp = 0;
    int n_err = 0;

    ws2812b_serializer #(
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .BIT_CYCLES  (BITC),
        .LATCH_CYCLES(LATCHC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .data_in(data_in),
        .valid  (valid),
        .latch  (latch),
        .ready  (ready),
        .led    (led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int rise;
        int width;
    } pulse_t;

    pulse_t obs_q[$];
    int     exp_q[$];

    logic led_prev = 1'b0;
    int   rise_c   = 0;
    int   hi_n     = 0;

    always @(negedge clk) begin
        if (led === 1'b1) begin
            if (!led_prev) begin
                rise_c = cyc;
                hi_n   = 1;
            end else begin
                hi_n++;
            end
        end else if (led_prev) begin
            obs_q.push_back('{rise: rise_c, width: hi_n});
        end
        led_prev = (led === 1'b1);
    end

    task automatic send_word(input logic [23:0] w, input logic l);
        for (int b = 23; b >= 0; b--) exp_q.push_back(w[b] ? T1H : T0H);
        @(negedge clk);
        data_in = w;
        latch   = l;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (ready) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic flush();
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        data_in = 24'hFFFFFF;
        latch   = 1'b0;
        valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (led !== 1'b0 || ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_hold: led=%b ready=%b, want led=0 ready=1", led, ready);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || led !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_accept: led=%b ready=%b, want led=1 ready=0", led, ready);
        end
        valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (led !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async: led=%b ready=%b, want led=0 ready=1", led, ready);
        end
        @(negedge clk);
        reset = 1'b0;
        flush();
    endtask

    task automatic test_single_word();
        int acc, n, prev;
        pulse_t p;
        int e;
        send_word(24'h800001, 1'b0);
        acc = cyc;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready_drop: ready=%b, want 0", ready);
        end
        wait_ready(3000, n);
        n_cmp++;
        if (n !== 24 * BITC) begin
            n_err++;
            $display("FAIL single_ready_time: %0d cycles, want %0d", n, 24 * BITC);
        end
        n_cmp++;
        if (obs_q.size() !== 24) begin
            n_err++;
            $display("FAIL single_count: %0d pulses, want 24", obs_q.size());
        end
        prev = acc - BITC;
        for (int i = 0; i < 24 && obs_q.size() > 0; i++) begin
            p = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (p.width !== e) begin
                n_err++;
                $display("FAIL single_width bit%0d: %0d, want %0d", 23 - i, p.width, e);
            end
            n_cmp++;
            if (p.rise - prev !== BITC) begin
                n_err++;
                $display("FAIL single_period bit%0d: %0d, want %0d", 23 - i, p.rise - prev, BITC);
            end
            prev = p.rise;
        end
        flush();
    endtask

    task automatic test_latch();
        int n;
        pulse_t p;
        int e;
        send_word(24'h000000, 1'b1);
        wait_ready(8000, n);
        n_cmp++;
        if (n !== 24 * BITC + LATCHC) begin
            n_err++;
            $display("FAIL latch_ready_time: %0d cycles, want %0d", n, 24 * BITC + LATCHC);
        end
        n_cmp++;
        if (obs_q.size() !== 24) begin
            n_err++;
            $display("FAIL latch_count: %0d pulses, want 24", obs_q.size());
        end
        for (int i = 0; i < 24 && obs_q.size() > 0; i++) begin
            p = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (p.width !== e) begin
                n_err++;
                $display("FAIL latch_width bit%0d: %0d, want %0d", 23 - i, p.width, e);
            end
        end
        n_cmp++;
        if (led !== 1'b0) begin
            n_err++;
            $display("FAIL latch_led_end: led=%b, want 0", led);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        int acc, n, prev, want_per;
        pulse_t p;
        int e;
        for (int b = 23; b >= 0; b--) exp_q.push_back(T1H);
        for (int b = 23; b >= 0; b--) exp_q.push_back(((24'h0F0F0F >> b) & 1) != 0 ? T1H : T0H);
        @(negedge clk);
        data_in = 24'hFFFFFF;
        latch   = 1'b0;
        valid   = 1'b1;
        @(negedge clk);
        acc = cyc;
        data_in = 24'h0F0F0F;
        wait_ready(3000, n);
        n_cmp++;
        if (n !== 24 * BITC) begin
            n_err++;
            $display("FAIL b2b_ready_time1: %0d cycles, want %0d", n, 24 * BITC);
        end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_accept: ready=%b, want 0", ready);
        end
        valid = 1'b0;
        wait_ready(3000, n);
        n_cmp++;
        if (n !== 24 * BITC) begin
            n_err++;
            $display("FAIL b2b_ready_time2: %0d cycles, want %0d", n, 24 * BITC);
        end
        n_cmp++;
        if (obs_q.size() !== 48) begin
            n_err++;
            $display("FAIL b2b_count: %0d pulses, want 48", obs_q.size());
        end
        prev = acc - BITC;
        for (int i = 0; i < 48 && obs_q.size() > 0; i++) begin
            p = obs_q.pop_front();
            e = exp_q.pop_front();
            // the single IDLE accept cycle stretches the last low time of word 1
            want_per = (i == 24) ? BITC + 1 : BITC;
            n_cmp++;
            if (p.width !== e) begin
                n_err++;
                $display("FAIL b2b_width pulse%0d: %0d, want %0d", i, p.width, e);
            end
            n_cmp++;
            if (p.rise - prev !== want_per) begin
                n_err++;
                $display("FAIL b2b_period pulse%0d: %0d, want %0d", i, p.rise - prev, want_per);
            end
            prev = p.rise;
        end
        flush();
    endtask

    task automatic test_busy_valid();
        int n;
        pulse_t p;
        int e;
        send_word(24'hC3A5F0, 1'b0);
        repeat (500) @(negedge clk);
        data_in = 24'hAAAAAA;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        wait_ready(3000, n);
        n_cmp++;
        if (n !== 24 * BITC - 501) begin
            n_err++;
            $display("FAIL busy_ready_time: %0d cycles, want %0d", n, 24 * BITC - 501);
        end
        n_cmp++;
        if (obs_q.size() !== 24) begin
            n_err++;
            $display("FAIL busy_count: %0d pulses, want 24", obs_q.size());
        end
        for (int i = 0; i < 24 && obs_q.size() > 0; i++) begin
            p = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (p.width !== e) begin
                n_err++;
                $display("FAIL busy_width bit%0d: %0d, want %0d", 23 - i, p.width, e);
            end
        end
        repeat (200) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL busy_no_second: %0d pulses ready=%b, want 0 pulses ready=1", obs_q.size(), ready);
        end
        flush();
    endtask

    task automatic test_midframe_reset();
        int acc, n, prev;
        pulse_t p;
        int e;
        send_word(24'hFFFFFF, 1'b0);
        repeat (10 * BITC + 30) @(negedge clk);
        n_cmp++;
        if (led !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre_led: led=%b, want 1", led);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (led !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_bit_reset: led=%b ready=%b, want led=0 ready=1", led, ready);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (led !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_no_resume: led=%b ready=%b, want led=0 ready=1", led, ready);
        end
        flush();

        send_word(24'h000000, 1'b1);
        repeat (24 * BITC + 100) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || led !== 1'b0) begin
            n_err++;
            $display("FAIL mid_in_latch: led=%b ready=%b, want led=0 ready=0", led, ready);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (led !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_latch_reset: led=%b ready=%b, want led=0 ready=1", led, ready);
        end
        @(negedge clk);
        reset = 1'b0;
        flush();

        send_word(24'h123456, 1'b0);
        acc = cyc;
        wait_ready(3000, n);
        n_cmp++;
        if (n !== 24 * BITC) begin
            n_err++;
            $display("FAIL mid_after_ready_time: %0d cycles, want %0d", n, 24 * BITC);
        end
        n_cmp++;
        if (obs_q.size() !== 24) begin
            n_err++;
            $display("FAIL mid_after_count: %0d pulses, want 24", obs_q.size());
        end
        prev = acc - BITC;
        for (int i = 0; i < 24 && obs_q.size() > 0; i++) begin
            p = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (p.width !== e) begin
                n_err++;
                $display("FAIL mid_after_width bit%0d: %0d, want %0d", 23 - i, p.width, e);
            end
            n_cmp++;
            if (p.rise - prev !== BITC) begin
                n_err++;
                $display("FAIL mid_after_period bit%0d: %0d, want %0d", 23 - i, p.rise - prev, BITC);
            end
            prev = p.rise;
        end
        flush();
    endtask

    initial begin
        reset   = 1'b0;
        valid   = 1'b0;
        latch   = 1'b0;
        data_in = '0;
        #1 reset = 1'b1;
        test_reset();
        test_single_word();
        test_latch();
        test_back_to_back();
        test_busy_valid();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
